// File: rtl/min_stream_sched.sv
// min_stream_sched
//
// Streaming minimum scheduler. Samples arrive over a valid/ready handshake and
// are collected into four lanes. Each full (or final partial) group goes through
// one shared min-of-four tree, and the group minimum is folded into a running
// minimum. When the burst ends, the running minimum is published on result for
// one done cycle. It is then held until the next accepted start.
//
// Optional feature: define MIN_STREAM_SCHED_INDEX_EN to track the 0-based index
// of the first occurrence of the minimum. Without it, no index storage or index
// muxing is built, and result_idx is tied to zero.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   start      - begin a burst (only honoured in IDLE)
//   len        - number of samples in the burst, latched on accepted start
//   in_data    - sample value
//   in_valid   - in_data is valid
//   in_ready   - a sample is accepted this cycle when in_valid is also high
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse while result/result_idx hold the final value
//   result     - burst minimum
//   result_idx - index of the first occurrence of the minimum (0 if disabled)

module min_stream_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [LEN_W-1:0] result_idx
);

  typedef enum logic [1:0] {StIdle, StCollect, StReduce, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [2:0]       fill_q;
  logic [WIDTH-1:0] lane_data_q [4];
  logic [WIDTH-1:0] run_min_q;
  logic [WIDTH-1:0] result_q;

  logic             xfer;
  logic             burst_end;
  logic [WIDTH-1:0] lane_val [4];
  logic             sel01, sel23, selp;
  logic [WIDTH-1:0] pair_min [2];
  logic [WIDTH-1:0] grp_min;
  logic             take_grp;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d = (len == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        in_ready = (fill_q < 3'd4) && (count_q < len_q);
        // Close the group on its fourth sample or on the last sample of the burst.
        if (in_ready && in_valid &&
            ((fill_q == 3'd3) || (LEN_W'(count_q + LEN_W'(1)) == len_q))) begin
          state_d = StReduce;
        end
      end
      StReduce: begin
        state_d = burst_end ? StDone : StCollect;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign xfer      = in_valid & in_ready;
  assign burst_end = (count_q == len_q);

  // ---------------------------------------------------------------------------
  // Min-of-four tree
  // Unfilled lanes are padded with all-ones. Padding always sits to the right
  // of real samples, so with strict-less-than selection it can never displace
  // a real sample.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_val[i] = (fill_q > 3'(i)) ? lane_data_q[i] : '1;
    end
    sel01       = lane_val[1] < lane_val[0];
    sel23       = lane_val[3] < lane_val[2];
    pair_min[0] = sel01 ? lane_val[1] : lane_val[0];
    pair_min[1] = sel23 ? lane_val[3] : lane_val[2];
    selp        = pair_min[1] < pair_min[0];
    grp_min     = selp ? pair_min[1] : pair_min[0];
    // Strict compare, so earlier groups keep ties.
    take_grp    = grp_min < run_min_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      count_q   <= '0;
      fill_q    <= '0;
      run_min_q <= '0;
      result_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        lane_data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            len_q     <= len;
            count_q   <= '0;
            fill_q    <= '0;
            run_min_q <= '1;
            // An empty burst goes straight to DONE, so publish the seed now.
            if (len == '0) begin
              result_q <= '1;
            end
          end
        end
        StCollect: begin
          if (xfer) begin
            lane_data_q[fill_q[1:0]] <= in_data;
            fill_q                   <= fill_q + 3'd1;
            count_q                  <= LEN_W'(count_q + LEN_W'(1));
          end
        end
        StReduce: begin
          fill_q <= '0;
          if (take_grp) begin
            run_min_q <= grp_min;
          end
          // Load the folded minimum on the way into DONE. This makes result
          // valid in the same cycle that done is high.
          if (burst_end) begin
            result_q <= take_grp ? grp_min : run_min_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = result_q;

  // ---------------------------------------------------------------------------
  // Optional first-occurrence index tracking
  // ---------------------------------------------------------------------------
`ifdef MIN_STREAM_SCHED_INDEX_EN
  logic [LEN_W-1:0] lane_idx_q [4];
  logic [LEN_W-1:0] pair_idx [2];
  logic [LEN_W-1:0] grp_idx;
  logic [LEN_W-1:0] run_idx_q;
  logic [LEN_W-1:0] result_idx_q;

  // The index follows the same selects as the data tree.
  always_comb begin
    pair_idx[0] = sel01 ? lane_idx_q[1] : lane_idx_q[0];
    pair_idx[1] = sel23 ? lane_idx_q[3] : lane_idx_q[2];
    grp_idx     = selp ? pair_idx[1] : pair_idx[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_idx_q    <= '0;
      result_idx_q <= '0;
      for (int i = 0; i < 4; i++) begin
        lane_idx_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            run_idx_q <= '0;
            if (len == '0) begin
              result_idx_q <= '0;
            end
          end
        end
        StCollect: begin
          if (xfer) begin
            lane_idx_q[fill_q[1:0]] <= count_q;
          end
        end
        StReduce: begin
          if (take_grp) begin
            run_idx_q <= grp_idx;
          end
          if (burst_end) begin
            result_idx_q <= take_grp ? grp_idx : run_idx_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_idx = result_idx_q;
`else
  assign result_idx = '0;
`endif

endmodule

// File: tb/tb_min_stream_sched.sv
// Scoreboard bench for min_stream_sched. Each burst pushes its hand-computed
// result, index and done cycle. A monitor pops one entry every time done is
// seen and compares it against the DUT outputs.

module tb_min_stream_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_idx;

  min_stream_sched #(
    .WIDTH(8),
    .LEN_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_idx(result_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [7:0] idx;
    int         due;   // expected done cycle, -1 = not checked
  } exp_t;

  exp_t       sb[$];
  logic [7:0] smp[$];
  int         n_cmp  = 0;
  int         n_err  = 0;
  int         n_done = 0;

  function automatic void chk(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void push_exp(logic [7:0] r, int ix, int due);
    exp_t e;
    e.res = r;
`ifdef MIN_STREAM_SCHED_INDEX_EN
    e.idx = 8'(ix);
`else
    e.idx = 8'd0;
    if (ix < 0) e.idx = 8'd0;
`endif
    e.due = due;
    sb.push_back(e);
  endfunction

  // Monitor: one scoreboard entry per done pulse.
  exp_t m_e;
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("result", result, m_e.res);
        chk("result_idx", result_idx, m_e.idx);
        if (m_e.due >= 0) chk("done_cycle", cyc, m_e.due);
      end
    end
  end

  // Present one sample and hold it until it transfers.
  task automatic feed(input logic [7:0] d);
    int k;
    in_data  = d;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("in_ready_at_done", in_ready, 0);
      chk("busy_at_done", busy, 1);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  // Burst with in_valid effectively held high; samples taken from smp.
  task automatic burst(input int n, input logic [7:0] r, input int ix);
    push_exp(r, ix, cyc + n + (n + 3) / 4 + 1);
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) feed(smp[i]);
    in_valid = 1'b0;
    wait_done();
  endtask

  logic       pat [7];
  logic [7:0] bp  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int got;
    reset    = 1'b1;
    start    = 1'b0;
    len      = 8'd0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_result_idx", result_idx, 0);
    reset = 1'b0;
    @(negedge clk);

    // Two full groups, continuous valid.
    smp = '{8'd50, 8'd40, 8'd90, 8'd30, 8'd70, 8'd31, 8'd99, 8'd60};
    burst(8, 8'd30, 3);
    // Partial group with all-ones samples vs all-ones padding.
    smp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    burst(5, 8'hFF, 0);
    smp = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};
    burst(6, 8'd4, 5);
    // Ties across lanes and groups.
    smp = '{8'd7, 8'd3, 8'd9, 8'd3, 8'd8, 8'd3};
    burst(6, 8'd3, 1);
    smp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd50, 8'd60};
    burst(7, 8'd5, 4);
    // Empty burst, then back-to-back start.
    smp = {};
    burst(0, 8'hFF, 0);
    smp = '{8'd5, 8'd2};
    burst(2, 8'd2, 1);

    // Backpressure, with a start pulse and len change mid-burst.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bp  = '{8'h20, 8'h10, 8'h30, 8'h10};
    push_exp(8'h10, 1, -1);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    p   = 0;
    got = 0;
    while (got < 4 && p < 40) begin
      in_valid = pat[p % 7];
      in_data  = bp[got];
      start    = (p == 2);
      if (p == 2) len = 8'd0;
      if (in_valid && in_ready) got++;
      @(negedge clk);
      p++;
    end
    start    = 1'b0;
    in_valid = 1'b1;
    chk("bp_transfers", got, 4);
    chk("in_ready_reduce", in_ready, 0);
    chk("busy_reduce", busy, 1);
    wait_done();
    in_valid = 1'b0;

    // Reset in the middle of a burst.
    start = 1'b1;
    len   = 8'd8;
    @(negedge clk);
    start = 1'b0;
    feed(8'd1);
    feed(8'd2);
    feed(8'd3);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    reset = 1'b0;
    @(negedge clk);
    smp = '{8'h42};
    burst(1, 8'h42, 0);

    repeat (3) @(negedge clk);
    chk("done_count", n_done, 9);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
